spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchronizer flops on ss, sck and din (minimum 2).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rstb  input  1  reset, asynchronous, active-low.
REQ-004 ss  input  1  SPI slave select from master, active-low, asynchronous to clk.
REQ-005 sck  input  1  SPI clock, mode 3 (idles high), asynchronous to clk.
REQ-006 din  input  1  MOSI serial data in.
REQ-007 dout  output  1  MISO serial data out; 1 when not selected.
REQ-008 dout_en  output  1  MISO driver enable; 1 while synchronized ss low.
REQ-009 mlb  input  1  bit order: 0 LSB first, 1 MSB first.
REQ-010 tdat  input  8  next transmit byte, written by tx_wr.
REQ-011 tx_wr  input  1  one-cycle strobe writing tdat to the transmit holding register.
REQ-012 tx_empty  output  1  holding register empty; ready for tx_wr.
REQ-013 rdata  output  8  last complete received byte.
REQ-014 rx_valid  output  1  one-cycle pulse; rdata updated this cycle.
REQ-015 underrun  output  1  one-cycle pulse; byte started with holding register empty.
REQ-016 abort  output  1  one-cycle pulse; ss deasserted mid-byte.
REQ-017 busy  output  1  1 while state is not IDLE.

Function
REQ-018 ss, sck, din shall each pass through SYNC_STAGES flops; edges detected by comparing last synchronized stage with one extra delayed flop.
REQ-019 clk shall be at least 8x sck frequency; behaviour for slower clk is unspecified.
REQ-020 FSM states: IDLE, LOAD, SHIFT; IDLE->LOAD on synchronized ss fall; LOAD->SHIFT unconditionally next cycle; SHIFT->LOAD after 8th sck rise while ss low; any state->IDLE on synchronized ss rise.
REQ-021 mlb shall be sampled at ss fall (IDLE->LOAD) and held for the whole ss-low frame.
REQ-022 LOAD: shift register loads holding register if tx_empty=0, sets tx_empty=1; if empty, loads 8'hFF and pulses underrun.
REQ-023 tx_wr in same cycle as LOAD with holding empty: tdat loads directly into shift register, tx_empty stays 1, no underrun.
REQ-024 tx_wr while holding full: holding overwritten with tdat, tx_empty stays 0.
REQ-025 dout shall present first bit (mlb?sreg[7]:sreg[0]) on first detected sck fall of each byte, then next bit on each later sck fall; shifted-in fill is 1.
REQ-026 On each detected sck rise in SHIFT: mlb=1 rx <= {rx[6:0],din}; mlb=0 rx <= {din,rx[7:1]}; 3-bit bit counter increments, wrapping 7->0.
REQ-027 On 8th rise: rdata <= completed byte and rx_valid pulses in same cycle (one cycle after edge detect); no consumer handshake, rdata overwritten by next byte.
REQ-028 Multiple bytes per ss-low frame shall be supported back-to-back via SHIFT->LOAD.
REQ-029 ss rise with bit counter 1..7: abort pulses, rdata unchanged, no rx_valid, counter cleared, partial byte discarded.
REQ-030 ss rise on same cycle as 8th rise: rx_valid takes priority, byte delivered, no abort.
REQ-031 In IDLE: dout=1, dout_en=0, sck edges ignored.

Reset
REQ-032 rstb low: state IDLE, dout=1, dout_en=0, rdata=8'h00, rx_valid=0, tx_empty=1, underrun=0, abort=0, busy=0, counter 0, synchronizers to 1 (ss, sck idle high).
REQ-033 rstb assertion mid-frame shall discard all partial data; after release block waits for a fresh ss fall.

Verification
REQ-034 tx_wr tdat=8'hA5, mlb=1, master sends 8'h3C mode 3 -> MISO bits 1,0,1,0,0,1,0,1; rdata=8'h3C, one rx_valid pulse, tx_empty=1.
REQ-035 mlb=0, tdat=8'h81, master sends 8'h01 -> MISO LSB-first 1,0,0,0,0,0,0,1; rdata=8'h01.
REQ-036 No tx_wr, master sends one byte -> underrun pulse at LOAD, MISO all 1s, rdata still updated.
REQ-037 Two bytes one frame (tx_wr 8'h11, then 8'h22 during byte 1) -> MISO 8'h11 then 8'h22, two rx_valid pulses.
REQ-038 ss rises after 4 sck rises -> abort pulse, no rx_valid, rdata unchanged, state IDLE, dout=1.
REQ-039 rstb pulsed low mid-byte -> all outputs at REQ-032 values; next full frame received correctly.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-3 slave, oversampled by the system clock. All SPI inputs are
// resynchronised and edge-detected. A one-byte transmit holding register
// feeds the shift register on each byte boundary. Received bytes are
// reported by a one-cycle rx_valid pulse.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rstb_i,
  input  logic       ss_i,
  input  logic       sck_i,
  input  logic       din_i,
  output logic       dout_o,
  output logic       dout_en_o,
  input  logic       mlb_i,
  input  logic [7:0] tdat_i,
  input  logic       tx_wr_i,
  output logic       tx_empty_o,
  output logic [7:0] rdata_o,
  output logic       rx_valid_o,
  output logic       underrun_o,
  output logic       abort_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, sck_sync_q, din_sync_q;
  logic                   ss_dly_q, sck_dly_q;
  logic                   ss_s, sck_s, din_s;
  logic                   ss_fall, ss_rise, sck_fall, sck_rise;
  logic                   rise_shift, last_bit, load_now;
  logic                   mlb_q, tx_empty_q, dout_q;
  logic                   rx_valid_q, underrun_q, abort_q;
  logic [2:0]             cnt_q;
  logic [7:0]             hold_q, sreg_q, rx_q, rx_next, rdata_q;

  assign ss_s  = ss_sync_q[SYNC_STAGES-1];
  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign din_s = din_sync_q[SYNC_STAGES-1];

  assign ss_fall  = ss_dly_q & ~ss_s;
  assign ss_rise  = ~ss_dly_q & ss_s;
  assign sck_fall = sck_dly_q & ~sck_s;
  assign sck_rise = ~sck_dly_q & sck_s;

  assign rise_shift = (state_q == SHIFT) && sck_rise;
  assign last_bit   = rise_shift && (cnt_q == 3'd7);
  // A LOAD cut short by ss rising does nothing; the frame is over.
  assign load_now   = (state_q == LOAD) && !ss_rise;
  assign rx_next    = mlb_q ? {rx_q[6:0], din_s} : {din_s, rx_q[7:1]};

  // Synchronizer chains plus one delayed copy for edge detection; idle high.
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      ss_sync_q  <= '1;
      sck_sync_q <= '1;
      din_sync_q <= '1;
      ss_dly_q   <= 1'b1;
      sck_dly_q  <= 1'b1;
    end else begin
      ss_sync_q  <= {ss_sync_q[SYNC_STAGES-2:0], ss_i};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din_i};
      ss_dly_q   <= ss_s;
      sck_dly_q  <= sck_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; ss release returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    if (ss_rise) state_d = IDLE;
  end

  // Control registers: bit order, counter, status pulses, MISO bit, rdata.
  always_ff @(posedge clk_i or negedge rstb_i) begin
    if (!rstb_i) begin
      mlb_q      <= 1'b1;
      cnt_q      <= 3'd0;
      tx_empty_q <= 1'b1;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
      dout_q     <= 1'b1;
      rdata_q    <= 8'h00;
    end else begin
      if (state_q == IDLE && ss_fall) mlb_q <= mlb_i;

      // A write during an empty LOAD goes straight to the shifter.
      if (tx_wr_i)       tx_empty_q <= load_now && tx_empty_q;
      else if (load_now) tx_empty_q <= 1'b1;

      underrun_q <= load_now && tx_empty_q && !tx_wr_i;
      rx_valid_q <= last_bit;
      // A completing byte wins over a simultaneous ss release.
      abort_q    <= ss_rise && (cnt_q != 3'd0) && !last_bit;

      if (ss_rise)         cnt_q <= 3'd0;
      else if (rise_shift) cnt_q <= cnt_q + 3'd1;

      if (last_bit) rdata_q <= rx_next;

      if (state_q == IDLE || ss_rise)      dout_q <= 1'b1;
      else if (state_q == SHIFT && sck_fall) dout_q <= mlb_q ? sreg_q[7] : sreg_q[0];
    end
  end

  // Data registers: holding register, transmit shifter, receive shifter.
  always_ff @(posedge clk_i) begin
    if (tx_wr_i && !(load_now && tx_empty_q)) hold_q <= tdat_i;

    if (load_now) begin
      if (!tx_empty_q)  sreg_q <= hold_q;
      else if (tx_wr_i) sreg_q <= tdat_i;
      else              sreg_q <= 8'hFF;
    end else if (state_q == SHIFT && sck_fall) begin
      sreg_q <= mlb_q ? {sreg_q[6:0], 1'b1} : {1'b1, sreg_q[7:1]};
    end

    if (rise_shift) rx_q <= rx_next;
  end

  assign dout_o     = dout_q;
  assign dout_en_o  = ~ss_s && (state_q != IDLE);
  assign tx_empty_o = tx_empty_q;
  assign rdata_o    = rdata_q;
  assign rx_valid_o = rx_valid_q;
  assign underrun_o = underrun_q;
  assign abort_o    = abort_q;
  assign busy_o     = (state_q != IDLE);

endmodule
